relu_backward_stream: RTL and testbench
=======================================

Name: relu_backward_stream

Overview:
Streaming, multi-lane ReLU backward layer. Computes bottom_diff = top_diff when bottom_data > 0, and top_diff * 2^-NEG_SHIFT otherwise (zero when NEG_SHIFT = 0), on LANES FP32 values per beat. It has a valid/ready handshake, a parametrised pipeline depth, frame tracking and a layer-id tag. It sits between the upstream layer's gradient stream and the forward-activation buffer in the CNN backward pass.

Parameters:
LANES, 8, FP32 elements per beat (1..32)
PIPE_STAGES, 2, register stages from input to output (1..4)
NEG_SHIFT, 0, negative slope = 2^-NEG_SHIFT; 0 means slope 0 (plain ReLU) (0..126)
CNT_W, 16, width of the per-frame beat counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id  in  32  layer id, sampled on first beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_last  in  1  final beat of frame
top_diff  in  LANES x 32  incoming gradient, FP32
bottom_data  in  LANES x 32  forward-pass input, FP32
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_last  out  1  final beat of frame
out_diff  out  LANES x 32  outgoing gradient, FP32
out_id  out  32  id of frame currently at output
beat_count  out  CNT_W  beats output in current frame (saturating)
neg_count  out  16  lanes taking negative path in last completed frame (stats; see option)

Behaviour:
- Reset (async, immediate): all stage valids 0, out_valid=0, out_last=0, out_diff=0, out_id=0, beat_count=0, neg_count=0. in_ready=1 once reset deasserts.
- Handshake: a transfer occurs when valid & ready on the same edge. The pipeline is stall-all: adv = !out_valid | out_ready, and in_ready = adv (combinational). A beat accepted at edge N appears at the output after edge N+PIPE_STAGES-1 when there is no stall. Stalls freeze all stages and hold data. Bubbles are carried, not collapsed.
- out_valid must not drop, and data must not change, while out_valid & !out_ready.
- Per-lane decision: pos = (sign==0) & (bits[30:0]!=0). +0 and -0 take the negative path. +Inf and +NaN are positive. -NaN is negative.
- Positive path: out = top_diff, bit-exact.
- Negative path, NEG_SHIFT=0: out = {top_diff sign, 31'b0}, i.e. a signed zero.
- Negative path, NEG_SHIFT>0:
  - top exponent 0xFF: pass unchanged (Inf/NaN preserved).
  - top exponent 0: out = signed zero (denormals flushed).
  - Otherwise e' = e - NEG_SHIFT. If e' <= 0, out = signed zero; else the exponent is replaced and the mantissa kept.
- Frame tracking:
  - A frame opens on the first beat accepted after reset or after an in_last beat; id is latched then and travels with the beats, so out_id is valid with every output beat.
  - beat_count increments on each output transfer and saturates at 2^CNT_W-1.
  - An output transfer with out_last=1 clears beat_count to 0 on the following edge.
- Simultaneous events: a new input accepted and the output transferred on the same edge is full throughput (1 beat/cycle). A one-beat frame (in_valid & in_last on the first beat) is legal.
- Reset mid-frame discards all in-flight beats; the next accepted beat opens a new frame.

Optional Feature:
RELU_BWD_STATS_EN:
- Defined:
  - A per-frame accumulator counts negative-path lanes on output transfers (saturating at 0xFFFF).
  - On the out_last transfer, the total including that beat is copied to neg_count and the accumulator clears.
- Undefined: the accumulator is not built and neg_count is tied to 0.
- Datapath and timing are identical in both cases.

Test Plan:
- LANES=8, NEG_SHIFT=0, top=0x3F800000 (1.0) on all lanes, bottom alternating 0x40000000/0xC0000000 -> out alternates 0x3F800000/0x00000000, latency PIPE_STAGES cycles.
- NEG_SHIFT=1, bottom=0xBF800000, top=0xC0400000 (-3.0) -> out 0xBFC00000 (-1.5). top=0x00800001 -> out 0x00000000. top=0x7F800000 -> 0x7F800000.
- bottom=+0 (0x00000000) and -0 (0x80000000), top=0xBF800000, NEG_SHIFT=0 -> out 0x80000000 for both lanes.
- Stream 20 beats with in_valid=1 while out_ready toggles 1,0,0,1: no beat lost or duplicated; out_diff is stable during stalls; in_ready=out_ready whenever out_valid=1.
- Two frames of 3 and 1 beats with id=5 then id=9 -> out_last on beats 3 and 4, out_id 5,5,5,9, beat_count 1,2,3 then 1. With RELU_BWD_STATS_EN and 4 negative lanes per beat, neg_count=12 after frame 1 and 4 after frame 2.
- Assert reset while 2 beats are in flight -> out_valid=0 immediately. Post-reset beat with id=7 gives out_id=7 and beat_count starts at 1.

Source files
------------

// File: rtl/relu_backward_stream.sv
`default_nettype none
// ============================================================================
// Module      : relu_backward_stream
// Description : Streaming multi-lane FP32 ReLU backward layer with stall-all
//               pipeline, frame/id tracking and optional negative-lane stats
//               (enabled by defining RELU_BWD_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module relu_backward_stream #(
    parameter int LANES       = 8,
    parameter int PIPE_STAGES = 2,
    parameter int NEG_SHIFT   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           id,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*32-1:0]   top_diff,
    input  logic [LANES*32-1:0]   bottom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [LANES*32-1:0]   out_diff,
    output logic [31:0]           out_id,
    output logic [CNT_W-1:0]      beat_count,
    output logic [15:0]           neg_count
);

    localparam int        c_DW    = LANES * 32;
    localparam int        c_LAST  = PIPE_STAGES - 1;
    localparam logic [7:0] c_SHIFT = 8'(NEG_SHIFT);

    logic                 w_adv;
    logic                 w_accept;
    logic                 w_xfer;
    logic [31:0]          w_beat_id;
    logic [c_DW-1:0]      w_diff;
    logic [LANES-1:0]     w_neg;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_last;
    logic [c_DW-1:0]        r_data [PIPE_STAGES];
    logic [31:0]            r_id   [PIPE_STAGES];
    logic                   r_open;
    logic [31:0]            r_frame_id;
    logic [CNT_W-1:0]       r_beat_count;
    logic                   r_clr;

    // Scaled negative slope; exponent underflow (incl. denormals) flushes to signed zero.
    function automatic logic [31:0] neg_path(input logic [31:0] t);
        logic [7:0] e;
        e = t[30:23];
        if (NEG_SHIFT == 0)
            return {t[31], 31'd0};
        else if (e == 8'hFF)
            return t;
        else if (e <= c_SHIFT)
            return {t[31], 31'd0};
        else
            return {t[31], e - c_SHIFT, t[22:0]};
    endfunction

    always_comb begin
        w_diff = '0;
        w_neg  = '0;
        for (int l = 0; l < LANES; l++) begin
            w_neg[l] = ~(~bottom_data[l*32+31] & (bottom_data[l*32 +: 31] != 31'd0));
            w_diff[l*32 +: 32] = w_neg[l] ? neg_path(top_diff[l*32 +: 32])
                                          : top_diff[l*32 +: 32];
        end
    end

    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign w_accept  = in_valid & w_adv;
    assign w_xfer    = out_valid & out_ready;
    assign w_beat_id = r_open ? r_frame_id : id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_last     <= '0;
            r_open     <= 1'b0;
            r_frame_id <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
                r_id[s]   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_open     <= ~in_last;
                r_frame_id <= w_beat_id;
            end
            if (w_adv) begin
                r_valid[0] <= in_valid;
                r_last[0]  <= in_valid & in_last;
                r_data[0]  <= w_diff;
                r_id[0]    <= w_beat_id;
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    r_last[s]  <= r_last[s-1];
                    r_data[s]  <= r_data[s-1];
                    r_id[s]    <= r_id[s-1];
                end
            end
        end
    end

    assign out_valid = r_valid[c_LAST];
    assign out_last  = r_last[c_LAST];
    assign out_diff  = r_data[c_LAST];
    assign out_id    = r_id[c_LAST];

    // Count stays visible for one cycle after the last beat, then restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_count <= '0;
            r_clr        <= 1'b0;
        end else begin
            r_clr <= w_xfer & out_last;
            if (r_clr)
                r_beat_count <= w_xfer ? CNT_W'(1) : '0;
            else if (w_xfer && (r_beat_count != {CNT_W{1'b1}}))
                r_beat_count <= r_beat_count + CNT_W'(1);
        end
    end

    assign beat_count = r_beat_count;

`ifdef RELU_BWD_STATS_EN
    localparam int c_NW = $clog2(LANES + 1);

    logic [c_NW-1:0] w_ncnt;
    logic [c_NW-1:0] r_ncnt [PIPE_STAGES];
    logic [15:0]     r_acc;
    logic [15:0]     r_neg_count;
    logic [16:0]     w_sum;
    logic [15:0]     w_sat;

    always_comb begin
        w_ncnt = '0;
        for (int l = 0; l < LANES; l++)
            w_ncnt = w_ncnt + c_NW'(w_neg[l]);
    end

    assign w_sum = {1'b0, r_acc} + 17'(r_ncnt[c_LAST]);
    assign w_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_neg_count <= '0;
            for (int s = 0; s < PIPE_STAGES; s++)
                r_ncnt[s] <= '0;
        end else begin
            if (w_adv) begin
                r_ncnt[0] <= w_ncnt;
                for (int s = 1; s < PIPE_STAGES; s++)
                    r_ncnt[s] <= r_ncnt[s-1];
            end
            if (w_xfer) begin
                if (out_last) begin
                    r_neg_count <= w_sat;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_sat;
                end
            end
        end
    end

    assign neg_count = r_neg_count;
`else
    assign neg_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_backward_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_backward_stream
// Description : Directed self-checking bench; two DUTs (NEG_SHIFT 0 and 1)
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_backward_stream;

    localparam int c_LANES = 8;
    localparam int c_PIPE  = 2;
`ifdef RELU_BWD_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  id;
    logic         in_valid, in_last, out_ready;
    logic [255:0] top_diff, bottom_data;
    logic         in_ready, out_valid, out_last;
    logic [255:0] out_diff;
    logic [31:0]  out_id;
    logic [15:0]  beat_count, neg_count;
    logic         in_ready1, out_valid1, out_last1;
    logic [255:0] out_diff1;
    logic [31:0]  out_id1;
    logic [15:0]  beat_count1, neg_count1;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] s_top [32];
    logic [255:0] s_bot [32];
    logic [31:0]  s_id  [32];
    bit           s_last[32];
    logic [255:0] e0    [32];
    logic [255:0] e1    [32];
    logic [31:0]  eid   [32];
    bit           elast [32];
    int           ebc   [32];
    int           enc   [32];

    relu_backward_stream #(.LANES(c_LANES), .PIPE_STAGES(c_PIPE), .NEG_SHIFT(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .id(id), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .top_diff(top_diff), .bottom_data(bottom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_diff(out_diff), .out_id(out_id), .beat_count(beat_count), .neg_count(neg_count)
    );

    relu_backward_stream #(.LANES(c_LANES), .PIPE_STAGES(c_PIPE), .NEG_SHIFT(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .id(id), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .top_diff(top_diff), .bottom_data(bottom_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
        .out_diff(out_diff1), .out_id(out_id1), .beat_count(beat_count1), .neg_count(neg_count1)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rep(input logic [31:0] x);
        return {8{x}};
    endfunction

    // Lane 0 gets a, lane 1 gets b, repeating.
    function automatic logic [255:0] alt(input logic [31:0] a, input logic [31:0] b);
        return {4{b, a}};
    endfunction

    task automatic set_beat(input int i, input logic [255:0] top, input logic [255:0] bot,
                            input logic [31:0] bid, input bit last, input logic [255:0] x0,
                            input logic [255:0] x1, input logic [31:0] xid, input bit xlast,
                            input int xbc, input int xnc);
        s_top[i] = top; s_bot[i] = bot; s_id[i] = bid; s_last[i] = last;
        e0[i] = x0; e1[i] = x1; eid[i] = xid; elast[i] = xlast; ebc[i] = xbc; enc[i] = xnc;
    endtask

    task automatic drive(input int i);
        in_valid    = 1'b1;
        top_diff    = s_top[i];
        bottom_data = s_bot[i];
        id          = s_id[i];
        in_last     = s_last[i];
    endtask

    function automatic bit rpat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return (cyc % 4 == 0) || (cyc % 4 == 3);
    endfunction

    // Inputs change just after posedge, outputs sampled on negedge.
    task automatic run(input string tag, input int n, input int mode, output int lat);
        int  ai = 0, k = 0, cyc = 0, a0 = -1, v0 = -1;
        bit  pend = 1'b0, xfer, acc;
        @(posedge clk); #1;
        drive(0);
        out_ready = rpat(mode, 0);
        while (k < n && cyc < 400) begin
            @(negedge clk);
            if (pend) begin
                chk_eq($sformatf("%s bc[%0d]", tag, k-1), 256'(beat_count), 256'(ebc[k-1]));
                if (elast[k-1])
                    chk_eq($sformatf("%s nc[%0d]", tag, k-1), 256'(neg_count),
                           256'(c_STATS ? enc[k-1] : 0));
                pend = 1'b0;
            end
            if (out_valid) begin
                if (v0 < 0) v0 = cyc;
                chk_eq($sformatf("%s d0[%0d]", tag, k), out_diff, e0[k]);
                chk_eq($sformatf("%s d1[%0d]", tag, k), out_diff1, e1[k]);
                chk_eq($sformatf("%s id[%0d]", tag, k), 256'(out_id), 256'(eid[k]));
                chk_eq($sformatf("%s last[%0d]", tag, k), 256'(out_last), 256'(elast[k]));
                chk_eq($sformatf("%s in_ready[%0d]", tag, k), 256'(in_ready), 256'(out_ready));
            end
            xfer = out_valid & out_ready;
            acc  = in_valid & in_ready;
            if (acc && a0 < 0) a0 = cyc;
            @(posedge clk); #1;
            cyc++;
            if (xfer) begin k++; pend = 1'b1; end
            if (acc) ai++;
            if (ai < n) drive(ai);
            else begin in_valid = 1'b0; in_last = 1'b0; end
            out_ready = rpat(mode, cyc);
        end
        chk_eq({tag, " beats_out"}, 256'(k), 256'(n));
        out_ready = 1'b1;
        @(negedge clk);
        if (pend) begin
            chk_eq($sformatf("%s bc[%0d]", tag, k-1), 256'(beat_count), 256'(ebc[k-1]));
            if (elast[k-1])
                chk_eq($sformatf("%s nc[%0d]", tag, k-1), 256'(neg_count),
                       256'(c_STATS ? enc[k-1] : 0));
        end
        chk_eq({tag, " no_extra"}, 256'(out_valid), 256'(0));
        lat = v0 - a0;
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        id = '0; top_diff = '0; bottom_data = '0;
        #12;
        chk_eq("rst out_valid", 256'(out_valid), 256'(0));
        chk_eq("rst out_diff", out_diff, 256'(0));
        chk_eq("rst out_id", 256'(out_id), 256'(0));
        chk_eq("rst beat_count", 256'(beat_count), 256'(0));
        chk_eq("rst neg_count", 256'(neg_count), 256'(0));
        #10 reset = 1'b0;
        #1 chk_eq("rst in_ready", 256'(in_ready), 256'(1));

        // Plain ReLU with alternating sign of forward input; latency check.
        set_beat(0, rep(32'h3F800000), alt(32'h40000000, 32'hC0000000), 32'd1, 1'b1,
                 alt(32'h3F800000, 32'h00000000), alt(32'h3F800000, 32'h3F000000),
                 32'd1, 1'b1, 1, 4);
        run("relu", 1, 0, lat);
        chk_eq("relu latency", 256'(lat), 256'(c_PIPE));

        // Frames of 3 and 1 beats; id only sampled on the first beat.
        set_beat(0, rep(32'hC0400000), alt(32'h3F800000, 32'hBF800000), 32'd5, 1'b0,
                 alt(32'hC0400000, 32'h80000000), alt(32'hC0400000, 32'hBFC00000),
                 32'd5, 1'b0, 1, 0);
        set_beat(1, rep(32'h00800001), alt(32'h3F800000, 32'hBF800000), 32'hDEADBEEF, 1'b0,
                 alt(32'h00800001, 32'h00000000), alt(32'h00800001, 32'h00000000),
                 32'd5, 1'b0, 2, 0);
        set_beat(2, rep(32'h7F800000), alt(32'h3F800000, 32'hBF800000), 32'hDEADBEEF, 1'b1,
                 alt(32'h7F800000, 32'h00000000), alt(32'h7F800000, 32'h7F800000),
                 32'd5, 1'b1, 3, 12);
        set_beat(3, rep(32'hBF800000), {2{32'h3F800000, 32'h80000000, 32'h3F800000, 32'h00000000}},
                 32'd9, 1'b1,
                 alt(32'h80000000, 32'hBF800000), alt(32'hBF000000, 32'hBF800000),
                 32'd9, 1'b1, 1, 4);
        run("frames", 4, 0, lat);

        // 20-beat stream under a 1,0,0,1 back-pressure pattern.
        for (int i = 0; i < 20; i++)
            set_beat(i, rep(32'h3F800000 + 32'(i)), alt(32'h40000000, 32'hC0000000),
                     (i == 0) ? 32'd3 : 32'h0BAD0000, (i == 19),
                     alt(32'h3F800000 + 32'(i), 32'h0),
                     alt(32'h3F800000 + 32'(i), 32'h3F000000 + 32'(i)),
                     32'd3, (i == 19), i + 1, 80);
        run("stream", 20, 1, lat);

        // Reset with two beats in flight and the output stalled.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0; id = 32'h11;
        top_diff = rep(32'h3F800000); bottom_data = rep(32'hBF800000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_eq("pre-rst out_valid", 256'(out_valid), 256'(1));
        reset = 1'b1;
        #1;
        chk_eq("mid-rst out_valid", 256'(out_valid), 256'(0));
        chk_eq("mid-rst out_diff", out_diff, 256'(0));
        chk_eq("mid-rst out_id", 256'(out_id), 256'(0));
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1 chk_eq("post-rst in_ready", 256'(in_ready), 256'(1));
        set_beat(0, rep(32'h40000000), rep(32'h3F800000), 32'd7, 1'b1,
                 rep(32'h40000000), rep(32'h40000000), 32'd7, 1'b1, 1, 0);
        run("post-rst", 1, 0, lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
